// File: rtl/param_load_ctrl.sv
// Parameter stream sequencer: accepts an ordered word stream after a start
// command and emits registered row-major (matrix) or linear (vector) writes.
module param_load_ctrl #(
    parameter  int unsigned ROWS = 4,
    parameter  int unsigned COLS = 16,
    parameter  int unsigned VLEN = 16,
    parameter  int unsigned DW   = 16,
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned VW   = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          target,
    input  logic          abort,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mat_write,
    output logic [RW-1:0] mat_sel_r,
    output logic [CW-1:0] mat_sel_c,
    output logic          vec_write,
    output logic [VW-1:0] vec_sel,
    output logic [DW-1:0] param_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_MAT = 2'd1,
        LOAD_VEC = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [VW-1:0] VEC_LAST = VW'(VLEN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [VW-1:0] vec_q;
    logic          loading;
    logic          accept;
    logic          mat_last;
    logic          vec_last;

    assign loading  = (state == LOAD_MAT) || (state == LOAD_VEC);
    assign in_ready = loading;
    assign busy     = loading;
    assign done     = (state == DONE);

    // Abort wins over a concurrent beat: that beat is dropped entirely.
    assign accept   = loading && in_valid && !abort;
    assign mat_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign vec_last = (vec_q == VEC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = target ? LOAD_VEC : LOAD_MAT;
                end
            end
            LOAD_MAT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && mat_last) begin
                    state_nxt = DONE;
                end
            end
            LOAD_VEC: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && vec_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
            vec_q <= '0;
        end else if (state == IDLE && start) begin
            row_q <= '0;
            col_q <= '0;
            vec_q <= '0;
        end else if (accept) begin
            if (state == LOAD_MAT && !mat_last) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (state == LOAD_VEC && !vec_last) begin
                vec_q <= vec_q + VW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_write <= 1'b0;
            vec_write <= 1'b0;
            mat_sel_r <= '0;
            mat_sel_c <= '0;
            vec_sel   <= '0;
            param_out <= '0;
        end else begin
            mat_write <= accept && (state == LOAD_MAT);
            vec_write <= accept && (state == LOAD_VEC);
            if (accept) begin
                param_out <= in_data;
                if (state == LOAD_MAT) begin
                    mat_sel_r <= row_q;
                    mat_sel_c <= col_q;
                end else begin
                    vec_sel <= vec_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_load_ctrl.sv
// Directed bench for param_load_ctrl: matrix/vector loads, bubbles, overrun,
// start-while-busy, abort and asynchronous reset mid-load.
module tb_param_load_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        target;
    logic        abort;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mat_write;
    logic [1:0]  mat_sel_r;
    logic [3:0]  mat_sel_c;
    logic        vec_write;
    logic [3:0]  vec_sel;
    logic [15:0] param_out;
    logic        busy;
    logic        done;

    int total;
    int bad;
    int exp_k;
    int dmode;
    int mat_cnt;
    int vec_cnt;
    int done_cnt;

    param_load_ctrl #(.ROWS(4), .COLS(16), .VLEN(16), .DW(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .target(target),
        .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mat_write(mat_write), .mat_sel_r(mat_sel_r),
        .mat_sel_c(mat_sel_c), .vec_write(vec_write), .vec_sel(vec_sel),
        .param_out(param_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_data(int k);
        if (dmode == 0) return 16'hD000 + 16'(k);
        return 16'hBEEF ^ 16'(k);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check any strobe against the next expected beat.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("one_strobe", 32'(mat_write & vec_write), 32'(0));
        if (mat_write) begin
            chk("mat_row", 32'(mat_sel_r), 32'(exp_k / 16));
            chk("mat_col", 32'(mat_sel_c), 32'(exp_k % 16));
            chk("mat_data", 32'(param_out), 32'(exp_data(exp_k)));
            mat_cnt++;
            exp_k++;
        end
        if (vec_write) begin
            chk("vec_sel", 32'(vec_sel), 32'(exp_k));
            chk("vec_data", 32'(param_out), 32'(exp_data(exp_k)));
            vec_cnt++;
            exp_k++;
        end
        if (done) done_cnt++;
    endtask

    task automatic begin_load(logic tgt, int mode, logic with_abort);
        exp_k = 0; mat_cnt = 0; vec_cnt = 0; done_cnt = 0; dmode = mode;
        start = 1'b1; target = tgt; abort = with_abort;
        tick();
        start = 1'b0; target = 1'b0; abort = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
        chk("ready_after_start", 32'(in_ready), 32'(1));
    endtask

    task automatic run_matrix(int start_glitch_at);
        begin_load(1'b0, 0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(k);
            if (k == start_glitch_at) begin
                start = 1'b1; target = 1'b1;
            end
            tick();
            start = 1'b0; target = 1'b0;
        end
        chk("mat_done_pulse", 32'(done), 32'(1));
        chk("mat_done_ready", 32'(in_ready), 32'(0));
        chk("mat_done_busy", 32'(busy), 32'(0));
        chk("mat_last_strobe", 32'(mat_write), 32'(1));
        in_valid = 1'b0;
        tick();
        chk("mat_idle_done", 32'(done), 32'(0));
        chk("mat_idle_strobe", 32'(mat_write), 32'(0));
        chk("mat_strobes", 32'(mat_cnt), 32'(64));
        chk("mat_no_vec", 32'(vec_cnt), 32'(0));
        chk("mat_done_cnt", 32'(done_cnt), 32'(1));
    endtask

    initial begin
        total = 0; bad = 0; exp_k = 0; dmode = 0;
        mat_cnt = 0; vec_cnt = 0; done_cnt = 0;
        reset_n = 1'b0; start = 1'b0; target = 1'b0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_mat_write", 32'(mat_write), 32'(0));
        chk("rst_vec_write", 32'(vec_write), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_param", 32'(param_out), 32'(0));
        chk("rst_sel", 32'({mat_sel_r, mat_sel_c, vec_sel}), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_no_accept", 32'(mat_write | vec_write), 32'(0));
        in_valid = 1'b0;

        // Matrix load, back-to-back
        run_matrix(-1);

        // Vector load with bubbles; start+abort together still starts
        begin_load(1'b1, 1, 1'b1);
        begin
            int sent = 0;
            for (int c = 0; c < 100 && sent < 16; c++) begin
                in_valid = (c % 3) != 2;
                in_data  = 16'hBEEF ^ 16'(sent);
                tick();
                if (in_valid) sent++;
            end
            chk("bub_sent", 32'(sent), 32'(16));
        end
        chk("bub_done", 32'(done), 32'(1));
        in_valid = 1'b0;
        tick();
        chk("bub_vec_cnt", 32'(vec_cnt), 32'(16));
        chk("bub_no_mat", 32'(mat_cnt), 32'(0));
        chk("bub_done_cnt", 32'(done_cnt), 32'(1));

        // Extra data: 20 words offered, only 16 accepted
        begin_load(1'b1, 1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hBEEF ^ 16'(k);
            tick();
            if (k >= 15) chk("extra_ready_low", 32'(in_ready), 32'(0));
            if (k >= 16) chk("extra_no_strobe", 32'(vec_write), 32'(0));
        end
        in_valid = 1'b0;
        tick();
        chk("extra_vec_cnt", 32'(vec_cnt), 32'(16));
        chk("extra_done_cnt", 32'(done_cnt), 32'(1));

        // start/target toggled mid-load are ignored
        run_matrix(5);

        // Abort at beat 10 with in_valid high
        begin_load(1'b0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(k);
            tick();
        end
        abort = 1'b1;
        in_data = 16'hD00A;
        tick();
        abort = 1'b0;
        chk("abort_no_strobe", 32'(mat_write), 32'(0));
        chk("abort_ready", 32'(in_ready), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        tick();
        in_valid = 1'b0;
        tick();
        chk("abort_mat_cnt", 32'(mat_cnt), 32'(10));
        chk("abort_done_cnt", 32'(done_cnt), 32'(0));
        begin_load(1'b1, 1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hBEEF ^ 16'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("post_abort_vec_cnt", 32'(vec_cnt), 32'(16));
        chk("post_abort_done_cnt", 32'(done_cnt), 32'(1));

        // Asynchronous reset mid-load after beat 30 is presented
        begin_load(1'b0, 0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(k);
            tick();
        end
        chk("pre_rst_strobe", 32'(mat_write), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_mat_write", 32'(mat_write), 32'(0));
        chk("arst_ready", 32'(in_ready), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_param", 32'(param_out), 32'(0));
        chk("arst_sel", 32'({mat_sel_r, mat_sel_c}), 32'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("post_rst_ready", 32'(in_ready), 32'(0));
        tick();
        chk("post_rst_idle", 32'(busy | mat_write | done), 32'(0));
        chk("post_rst_mat_cnt", 32'(mat_cnt), 32'(30));
        run_matrix(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_load_ctrl.md
Name: param_load_ctrl

Overview:
Sequencer that streams 16-bit RNN parameters from a valid/ready source into either the weight-matrix loader (loader_2d) or the bias/vector loader (loader_1d). It generates row-major addresses and write strobes, so software or DMA only pushes an ordered word stream after a one-cycle start command. It sits between the host/DMA interface and the parameter loaders.

Parameters:
ROWS, 4, matrix row count; row select width RW = $clog2(ROWS)
COLS, 16, matrix column count; column select width CW = $clog2(COLS)
VLEN, 16, vector length; vector select width VW = $clog2(VLEN)
DW, 16, parameter word width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin load when IDLE; sampled only in IDLE
target  in  1  0 = matrix, 1 = vector; latched with start
abort  in  1  synchronous cancel; returns to IDLE
in_data  in  DW  parameter word
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts a word this cycle
mat_write  out  1  write strobe to matrix loader
mat_sel_r  out  RW  matrix row address
mat_sel_c  out  CW  matrix column address
vec_write  out  1  write strobe to vector loader
vec_sel  out  VW  vector address
param_out  out  DW  data to both loaders
busy  out  1  high in LOAD_MAT/LOAD_VEC
done  out  1  one-cycle pulse on load completion

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; address counters and latched target cleared. Takes effect mid-load; no further strobes after reset deassertion.
- States: IDLE, LOAD_MAT, LOAD_VEC, DONE.
- IDLE: in_ready=0, busy=0. start=1 -> LOAD_MAT (target=0) or LOAD_VEC (target=1) next cycle; counters zeroed.
- LOAD_*: in_ready=1, busy=1. Beat accepted when in_valid && in_ready.
- Accepted beat at cycle N -> cycle N+1: write strobe (mat_write or vec_write, never both) high for exactly one cycle, param_out = beat data, sel outputs = beat address. Latency 1; all outputs registered.
- No beat accepted -> strobes 0; param_out and sel outputs hold last values.
- Matrix addressing row-major: col increments per beat; at col=COLS-1 wrap to 0 and row++. Beat k -> row k/COLS, col k%COLS.
- Vector addressing: vec_sel = beat index 0..VLEN-1.
- Last beat (matrix index ROWS*COLS-1, vector index VLEN-1): next state DONE; in_ready drops the cycle after acceptance (exactly ROWS*COLS or VLEN words ever accepted).
- DONE: one cycle; done=1, in_ready=0, busy=0; final write strobe occurs in this same cycle. Then IDLE.
- start while not IDLE: ignored. in_valid in IDLE/DONE: not accepted (in_ready=0).
- abort=1 in LOAD_*: next cycle IDLE, in_ready=0, no done pulse; a beat accepted in the abort cycle is dropped (no strobe). Abort has priority over beat acceptance. abort in IDLE/DONE: no effect.
- start and abort both high in IDLE: abort ignored, load starts.
- Counter arithmetic: RW/CW/VW-bit unsigned; no wrap beyond the final index.

Test Plan:
- Matrix load: start, target=0, 64 back-to-back beats in_data=16'hD000+k -> 64 mat_write pulses, beat k seen at row k/16, col k%16, data 16'hD000+k; done in the cycle of the 64th strobe; vec_write never high.
- Vector load with bubbles: target=1, 16 beats 16'hBEEF^k, in_valid deasserted every third cycle -> exactly 16 vec_write pulses at vec_sel 0..15; strobe count equals accepted beats; done once.
- Extra data: 20 valid words offered on vector load -> only 16 accepted; in_ready=0 from DONE onward; no strobe after done.
- start while busy: pulse start and toggle target at beat 5 of a matrix load -> ignored; load completes as matrix with 64 strobes.
- abort at beat 10 of matrix load with in_valid=1 -> 10 strobes total (addresses 0..9), no done, IDLE next cycle; a subsequent vector load runs cleanly from vec_sel=0.
- reset_n low mid-load at beat 30, async between edges -> all outputs 0 immediately; after release IDLE, in_ready=0, fresh matrix load starts at row 0, col 0.
